// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the parametrised decode/mux interconnect:
// transfer types, response codes and the default-slave state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // NONSEQ and SEQ are the only transfer types that demand a real response.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_decode_mux_n_if.sv
// Bus bundle between the AHB master, the interconnect and its slave slots.
// The interconnect uses the slave modport; the master side drives everything else.
interface ahb_decode_mux_n_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);

  logic [ADDR_WIDTH-1:0]            haddr;
  logic [1:0]                       htrans;
  logic                             hready;
  logic [1:0]                       hresp;
  logic [DATA_WIDTH-1:0]            hrdata;
  logic [NUM_SLAVES-1:0]            hsel_s;
  logic [NUM_SLAVES-1:0]            hreadyout_s;
  logic [2*NUM_SLAVES-1:0]          hresp_s;
  logic [DATA_WIDTH*NUM_SLAVES-1:0] hrdata_s;

  modport slave (
    input  haddr, htrans, hreadyout_s, hresp_s, hrdata_s,
    output hready, hresp, hrdata, hsel_s
  );

  modport master (
    output haddr, htrans, hreadyout_s, hresp_s, hrdata_s,
    input  hready, hresp, hrdata, hsel_s
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers NONSEQ/SEQ to unmapped or disabled slots
// with the two-cycle AHB ERROR response, and IDLE/BUSY with zero-wait OKAY.
module ahb_default_slave (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       sel_dp_valid,
  input  logic       hready_in,
  output logic       hreadyout,
  output logic [1:0] hresp
);
  import ahb_pkg::*;

  ds_state_e state_q, state_d;

  always_ff @(posedge hclk) begin
    if (!hresetn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  // ERR2 overlaps the next address phase, so a fresh error may follow at once.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE: if (hready_in && sel_dp_valid) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = (hready_in && sel_dp_valid) ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state_q)
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      DS_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_decode_mux_n.sv
// One-master / NUM_SLAVES-slave AHB-Lite interconnect: address decode, data-phase
// select register, response mux and default slave. Optional timeout: AHB_TIMEOUT_EN.
module ahb_decode_mux_n #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    SEL_MSB        = 31,
  parameter int                    SEL_LSB        = 30,
  parameter logic [NUM_SLAVES-1:0] SLOT_MASK      = 4'b1110,
  parameter int                    TIMEOUT_CYCLES = 16,
  localparam int                   SLOT_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  ahb_decode_mux_n_if.slave     bus,
  input  logic                  timeout_clr,
  output logic                  timeout_irq,
  output logic [SLOT_W-1:0]     timeout_slot
);
  import ahb_pkg::*;

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam int DEF   = NUM_SLAVES;

  logic [SEL_W-1:0]      idx;
  logic [NUM_SLAVES:0]   dec;
  logic [NUM_SLAVES:0]   dsel_q, dsel_d;
  logic                  hready_int;
  logic [1:0]            hresp_int;
  logic [DATA_WIDTH-1:0] hrdata_int;
  logic                  ds_hreadyout;
  logic [1:0]            ds_hresp;
  logic [ADDR_WIDTH-1:0] unused_addr;
  logic                  unused_trans;

  assign idx = bus.haddr[SEL_MSB:SEL_LSB];

  // Anything not landing on a populated slot falls through to the default slave.
  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SLOT_MASK[i] && (idx == SEL_W'(i))) dec[i] = 1'b1;
    end
    dec[DEF] = ~|dec[NUM_SLAVES-1:0];
  end

  assign bus.hsel_s = dec[NUM_SLAVES-1:0];
  assign dsel_d     = hready_int ? dec : dsel_q;

  always_ff @(posedge hclk) begin
    if (!hresetn) dsel_q <= '0;
    else          dsel_q <= dsel_d;
  end

  ahb_default_slave u_default_slave (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .sel_dp_valid (dec[DEF] && is_active(bus.htrans)),
    .hready_in    (hready_int),
    .hreadyout    (ds_hreadyout),
    .hresp        (ds_hresp)
  );

  always_comb begin
    hready_int = 1'b1;
    hresp_int  = HRESP_OKAY;
    hrdata_int = '0;
    if (dsel_q[DEF]) begin
      hready_int = ds_hreadyout;
      hresp_int  = ds_hresp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        hready_int = bus.hreadyout_s[i];
        hresp_int  = bus.hresp_s[2*i +: 2];
        hrdata_int = bus.hrdata_s[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  assign bus.hready = hready_int;
  assign bus.hresp  = hresp_int;
  assign bus.hrdata = hrdata_int;

  assign unused_addr  = bus.haddr;
  assign unused_trans = bus.htrans[0];

`ifdef AHB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              tmo_irq_q, tmo_irq_d;
  logic [SLOT_W-1:0] tmo_slot_q, tmo_slot_d;
  logic [SLOT_W-1:0] cur_slot;
  logic              stall;
  logic              hit;

  // Counter saturates so a long stall raises the flag exactly once.
  always_comb begin
    cur_slot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) cur_slot = SLOT_W'(i);
    end
    stall     = (|dsel_q[NUM_SLAVES-1:0]) && !hready_int;
    tmo_cnt_d = '0;
    hit       = 1'b0;
    if (stall) begin
      hit       = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      tmo_cnt_d = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);
    end
    tmo_irq_d  = tmo_irq_q;
    tmo_slot_d = tmo_slot_q;
    if (timeout_clr) tmo_irq_d = 1'b0;
    if (hit) begin
      tmo_irq_d  = 1'b1;
      tmo_slot_d = cur_slot;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      tmo_cnt_q  <= '0;
      tmo_irq_q  <= 1'b0;
      tmo_slot_q <= '0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_irq_q  <= tmo_irq_d;
      tmo_slot_q <= tmo_slot_d;
    end
  end

  assign timeout_irq  = tmo_irq_q;
  assign timeout_slot = tmo_slot_q;
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  logic unused_clr;

  assign unused_clr   = timeout_clr;
  assign timeout_irq  = 1'b0;
  assign timeout_slot = '0;
`endif

endmodule

// File: tb/tb_ahb_decode_mux_n.sv
// Randomised bench for ahb_decode_mux_n against a transaction-level model of
// the current data phase; directed sequences cover the documented scenarios.
module tb_ahb_decode_mux_n;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam logic [NS-1:0] MASK = 4'b1110;
`ifdef AHB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic       hclk = 1'b0;
  logic       hresetn = 1'b0;
  logic       timeout_clr = 1'b0;
  logic       timeout_irq;
  logic [1:0] timeout_slot;

  int checks = 0;
  int errors = 0;

  // Model: m_cur = -1 none, 0..NS-1 slot, NS default; m_err = 2 first, 1 second error cycle.
  int m_cur  = -1;
  int m_err  = 0;
  int m_cnt  = 0;
  int m_irq  = 0;
  int m_slot = 0;

  logic [NS-1:0]    r_rdy;
  logic [2*NS-1:0]  r_resp;
  logic [DW*NS-1:0] r_data;

  ahb_decode_mux_n_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  ahb_decode_mux_n #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .SEL_MSB        (31),
    .SEL_LSB        (30),
    .SLOT_MASK      (MASK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .bus          (bus),
    .timeout_clr  (timeout_clr),
    .timeout_irq  (timeout_irq),
    .timeout_slot (timeout_slot)
  );

  always #5 hclk = ~hclk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle, checks outputs mid-cycle, then advances the model across the edge.
  task automatic applyStimulus(input logic rst_n, input logic [AW-1:0] addr, input logic [1:0] trans,
                               input logic [NS-1:0] rdy, input logic [2*NS-1:0] resp,
                               input logic [DW*NS-1:0] data, input logic clr);
    int         idx;
    int         tgt;
    logic       e_ready;
    logic [1:0] e_resp;
    logic [DW-1:0] e_data;
    logic [NS-1:0] e_sel;
    hresetn         = rst_n;
    bus.haddr       = addr;
    bus.htrans      = trans;
    bus.hreadyout_s = rdy;
    bus.hresp_s     = resp;
    bus.hrdata_s    = data;
    timeout_clr     = clr;
    @(negedge hclk);
    idx   = int'(addr[AW-1:AW-2]);
    tgt   = MASK[idx] ? idx : NS;
    e_sel = '0;
    if (tgt < NS) e_sel[tgt] = 1'b1;
    e_ready = 1'b1;
    e_resp  = 2'b00;
    e_data  = '0;
    if (m_cur >= 0 && m_cur < NS) begin
      e_ready = rdy[m_cur];
      e_resp  = resp[2*m_cur +: 2];
      e_data  = data[DW*m_cur +: DW];
    end else if (m_cur == NS && m_err > 0) begin
      e_ready = (m_err == 1);
      e_resp  = 2'b01;
    end
    checkOutput("hready", 64'(bus.hready), 64'(e_ready));
    checkOutput("hresp", 64'(bus.hresp), 64'(e_resp));
    checkOutput("hrdata", 64'(bus.hrdata), 64'(e_data));
    checkOutput("hsel_s", 64'(bus.hsel_s), 64'(e_sel));
    checkOutput("timeout_irq", 64'(timeout_irq), 64'(m_irq));
    checkOutput("timeout_slot", 64'(timeout_slot), 64'(m_slot));
    if (!rst_n) begin
      m_cur  = -1;
      m_err  = 0;
      m_cnt  = 0;
      m_irq  = 0;
      m_slot = 0;
    end else begin
`ifdef AHB_TIMEOUT_EN
      begin
        bit stall;
        stall = (m_cur >= 0) && (m_cur < NS) && !e_ready;
        m_cnt = stall ? m_cnt + 1 : 0;
        if (clr) m_irq = 0;
        if (m_cnt == TMO) begin
          m_irq  = 1;
          m_slot = m_cur;
        end
      end
`endif
      if (e_ready) begin
        m_cur = tgt;
        m_err = (tgt == NS && trans[1]) ? 2 : 0;
      end else if (m_err == 2) begin
        m_err = 1;
      end
    end
    @(posedge hclk);
    #1;
  endtask

  initial begin
    bus.haddr       = '0;
    bus.htrans      = 2'b00;
    bus.hreadyout_s = '1;
    bus.hresp_s     = '0;
    bus.hrdata_s    = '0;
    repeat (2) @(posedge hclk);
    #1;
    $display("[TB] reset state");
    applyStimulus(1'b0, 32'h0, 2'b00, 4'hF, 8'h00, '0, 1'b0);

    $display("[TB] incr4 to slot 1");
    applyStimulus(1'b1, 32'h4000001E, 2'b10, 4'hF, 8'h00, '0, 1'b0);
    for (int b = 1; b < 4; b++)
      applyStimulus(1'b1, 32'h4000001E + 32'(4*b), 2'b11, 4'hF, 8'h00, '0, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, '0, 1'b0);

    $display("[TB] back-to-back slots 3 and 2");
    r_data = {32'h000000AA, 32'h00000055, 64'h0};
    applyStimulus(1'b1, 32'hC000004E, 2'b10, 4'hF, 8'h00, r_data, 1'b0);
    applyStimulus(1'b1, 32'h8000005E, 2'b10, 4'hF, 8'h00, r_data, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, r_data, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, r_data, 1'b0);

    $display("[TB] masked slot 0 error then idle");
    applyStimulus(1'b1, 32'h00000010, 2'b10, 4'hF, 8'h00, '0, 1'b0);
    applyStimulus(1'b1, 32'h00000010, 2'b00, 4'hF, 8'h00, '0, 1'b0);
    applyStimulus(1'b1, 32'h00000010, 2'b00, 4'hF, 8'h00, '0, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, '0, 1'b0);

    $display("[TB] slot 1 wait states");
    r_data = {32'h0, 32'h0, 32'h12345678, 32'h0};
    applyStimulus(1'b1, 32'h40000000, 2'b10, 4'hF, 8'h00, r_data, 1'b0);
    repeat (3) applyStimulus(1'b1, 32'h80000000, 2'b10, 4'b1101, 8'h00, r_data, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 2'b10, 4'hF, 8'h00, r_data, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, r_data, 1'b0);

    $display("[TB] reset during first error cycle");
    applyStimulus(1'b1, 32'h00000010, 2'b10, 4'hF, 8'h00, '0, 1'b0);
    applyStimulus(1'b0, 32'h00000010, 2'b10, 4'hF, 8'h00, '0, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, '0, 1'b0);

    $display("[TB] slot 2 long stall");
    applyStimulus(1'b1, 32'h80000000, 2'b10, 4'hF, 8'h00, '0, 1'b0);
    repeat (6) applyStimulus(1'b1, 32'h0, 2'b00, 4'b1011, 8'h00, '0, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, '0, 1'b0);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, '0, 1'b1);
    applyStimulus(1'b1, 32'h0, 2'b00, 4'hF, 8'h00, '0, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < NS; s++) begin
        r_rdy[s]           = ($urandom_range(0, 3) != 0);
        r_resp[2*s +: 2]   = 2'($urandom_range(0, 1));
        r_data[DW*s +: DW] = $urandom;
      end
      applyStimulus(($urandom_range(0, 49) != 0), $urandom, 2'($urandom_range(0, 3)),
                    r_rdy, r_resp, r_data, ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
